row_adder_sched: RTL and testbench

- Clocked scheduler that shares one row adder among NUM_REQ processing-element requesters.
- Each requester offers 8-bit partial sums, each tagged with a 2-bit output column (01/10/11).
- The block arbitrates round-robin and forwards one partial per transfer through a one-entry output register.
- It counts contributions per column. Once every column holds PSUM_PER_COL partials, it raises `fire` so the adder thresholds and emits its spike packet, then clears the counts for the next timestep.

---
 rtl/row_adder_if.sv | 28 ++
 rtl/row_adder_sched.sv | 156 +++++++++++++++
 tb/tb_row_adder_sched.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/row_adder_if.sv
// Requester/adder handshake bundle for the shared row-adder scheduler.
interface row_adder_if #(
  parameter int NUM_REQ = 3,
  parameter int WIDTH_D = 8
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [2*NUM_REQ-1:0]       req_col;
  logic [WIDTH_D*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       add_valid;
  logic [1:0]                 add_col;
  logic [WIDTH_D-1:0]         add_data;
  logic                       add_ready;
  logic                       fire;
  logic                       fire_ack;
  logic                       err_col;
  logic [1:0]                 grant_id;

  modport master (
    output req_valid, req_col, req_data, add_ready, fire_ack,
    input  req_ready, add_valid, add_col, add_data, fire, err_col, grant_id
  );

  modport slave (
    input  req_valid, req_col, req_data, add_ready, fire_ack,
    output req_ready, add_valid, add_col, add_data, fire, err_col, grant_id
  );
endinterface

// File: rtl/row_adder_sched.sv
// Round-robin scheduler sharing one row adder among NUM_REQ PE requesters;
// counts partials per column and raises fire once every column is complete.
module row_adder_lane #(
  parameter int NUM_COL = 3
) (
  input  logic               valid,
  input  logic [1:0]         col,
  input  logic [NUM_COL-1:0] full,
  input  logic               open,
  output logic               elig,
  output logic [1:0]         col_eff
);
  logic blocked;

  // Tags beyond NUM_COL degrade to the discard tag 00.
  always_comb begin
    col_eff = (int'(col) <= NUM_COL) ? col : 2'd0;
    blocked = 1'b0;
    for (int c = 0; c < NUM_COL; c++)
      if (col_eff == 2'(c + 1) && full[c]) blocked = 1'b1;
    elig = valid && open && !blocked;
  end
endmodule

module row_adder_sched #(
  parameter int NUM_REQ      = 3,
  parameter int WIDTH_D      = 8,
  parameter int NUM_COL      = 3,
  parameter int PSUM_PER_COL = 3
) (
  input logic       clk,
  input logic       rst,
  row_adder_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {COLLECT, FIRE} state_t;
  typedef struct packed {
    logic [1:0]         col;
    logic [WIDTH_D-1:0] data;
  } psum_t;

  state_t                    state, state_nxt;
  logic [PW-1:0]             ptr;
  logic [NUM_COL-1:0][1:0]   cnt;
  logic [NUM_COL-1:0]        full;
  logic                      all_full;
  logic                      out_vld;
  psum_t                     out_q;
  logic [1:0]                gid;
  logic                      err_q;
  logic                      fire_o;
  logic                      slot_free, open;
  logic [NUM_REQ-1:0]        elig;
  logic [NUM_REQ-1:0][1:0]   col_eff;
  logic                      gnt_any;
  logic [PW-1:0]             gnt_idx;
  int                        scan_idx;
  psum_t                     sel;
  logic                      load;

  always_comb begin
    full = '0;
    for (int c = 0; c < NUM_COL; c++) full[c] = int'(cnt[c]) >= PSUM_PER_COL;
  end
  assign all_full = &full;

  // Pass-through: a slot being drained this cycle can be refilled this cycle.
  assign slot_free = !out_vld || bus.add_ready;
  assign open      = (state == COLLECT) && slot_free;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    row_adder_lane #(.NUM_COL(NUM_COL)) u_lane (
      .valid   (bus.req_valid[i]),
      .col     (bus.req_col[2*i +: 2]),
      .full    (full),
      .open    (open),
      .elig    (elig[i]),
      .col_eff (col_eff[i])
    );
  end

  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (int'(ptr) + k) % NUM_REQ;
      if (!gnt_any && elig[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(scan_idx);
      end
    end
    bus.req_ready = '0;
    if (gnt_any) bus.req_ready[gnt_idx] = 1'b1;
  end

  assign sel.col  = col_eff[gnt_idx];
  assign sel.data = bus.req_data[int'(gnt_idx)*WIDTH_D +: WIDTH_D];
  assign load     = gnt_any && (sel.col != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  // FIRE waits for the final partial to leave the output register.
  always_comb begin
    state_nxt = state;
    fire_o    = 1'b0;
    case (state)
      COLLECT: if (all_full && (!out_vld || bus.add_ready)) state_nxt = FIRE;
      FIRE: begin
        fire_o = 1'b1;
        if (bus.fire_ack) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_q   <= '0;
      ptr     <= '0;
      gid     <= 2'd0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      err_q <= gnt_any && (sel.col == 2'd0);
      if (gnt_any) begin
        ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
        gid <= 2'(gnt_idx);
      end
      if (load) begin
        out_vld <= 1'b1;
        out_q   <= sel;
      end else if (bus.add_ready) begin
        out_vld <= 1'b0;
      end
      if (state == FIRE && bus.fire_ack) begin
        cnt <= '0;
      end else if (load) begin
        for (int c = 0; c < NUM_COL; c++)
          if (sel.col == 2'(c + 1)) cnt[c] <= cnt[c] + 2'd1;
      end
    end
  end

  assign bus.add_valid = out_vld;
  assign bus.add_col   = out_q.col;
  assign bus.add_data  = out_q.data;
  assign bus.fire      = fire_o;
  assign bus.err_col   = err_q;
  assign bus.grant_id  = gid;
endmodule

// File: tb/tb_row_adder_sched.sv
// Directed scoreboard bench for row_adder_sched: fairness, column stall,
// backpressure, tag-00 discard and reset during FIRE.
module tb_row_adder_sched;
  localparam int NR = 3;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  row_adder_if #(.NUM_REQ(NR), .WIDTH_D(W)) bus();

  row_adder_sched #(.NUM_REQ(NR), .WIDTH_D(W), .NUM_COL(3), .PSUM_PER_COL(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         rem [NR];
  logic [1:0] rcol [NR];
  logic [7:0] rdat [NR];
  logic [9:0] sb [$];
  int         gq [$];
  int         sum [4];
  int         cyc = 0;
  int         first_gnt = -1;
  int         first_av = -1;
  int         n0;
  int         steps;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]       = rem[i] > 0;
      bus.req_col[2*i +: 2]  = rcol[i];
      bus.req_data[W*i +: W] = rdat[i];
    end
  endtask

  task automatic peek();
    apply();
    #1;
  endtask

  // One clock cycle: settle, log handshakes into scoreboard, advance to next negedge.
  task automatic tick();
    logic [9:0] e;
    apply();
    #1;
    if (bus.add_valid && first_av < 0) first_av = cyc;
    if (bus.add_valid && bus.add_ready && !rst) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
      else begin
        e = sb.pop_front();
        chk("sb_out", {22'd0, bus.add_col, bus.add_data}, {22'd0, e});
      end
      sum[bus.add_col] += int'(bus.add_data);
    end
    for (int i = 0; i < NR; i++)
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        gq.push_back(i);
        if (first_gnt < 0) first_gnt = cyc;
        if (rcol[i] != 2'd0) sb.push_back({rcol[i], rdat[i]});
        rem[i]--;
      end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input int n, input logic [1:0] c, input logic [7:0] d);
    rem[i] = n; rcol[i] = c; rdat[i] = d;
  endtask

  initial begin
    bus.add_ready = 1'b0;
    bus.fire_ack  = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 0, 2'd0, 8'd0);
    for (int c = 0; c < 4; c++) sum[c] = 0;
    apply();
    @(negedge clk);

    // Reset then idle
    rst = 1'b1;
    tick(); tick();
    peek();
    chk("rst_add_valid", {31'd0, bus.add_valid}, 0);
    chk("rst_add_col", {30'd0, bus.add_col}, 0);
    chk("rst_add_data", {24'd0, bus.add_data}, 0);
    chk("rst_fire", {31'd0, bus.fire}, 0);
    chk("rst_err_col", {31'd0, bus.err_col}, 0);
    chk("rst_grant_id", {30'd0, bus.grant_id}, 0);
    chk("rst_req_ready", {29'd0, bus.req_ready}, 0);
    rst = 1'b0;
    tick();
    chk("idle_req_ready", {29'd0, bus.req_ready}, 0);

    // Fairness: three requesters, three partials each
    set_req(0, 3, 2'd1, 8'd5);
    set_req(1, 3, 2'd2, 8'd14);
    set_req(2, 3, 2'd3, 8'd8);
    bus.add_ready = 1'b1;
    gq.delete(); first_gnt = -1; first_av = -1;
    for (int k = 0; k < 40 && !bus.fire; k++) tick();
    chk("fair_fire", {31'd0, bus.fire}, 1);
    chk("fair_ngrants", gq.size(), 9);
    for (int k = 0; k < 9 && k < gq.size(); k++) chk("fair_order", gq[k], k % 3);
    chk("fair_latency", first_av - first_gnt, 1);
    chk("fair_sum1", sum[1], 15);
    chk("fair_sum2", sum[2], 42);
    chk("fair_sum3", sum[3], 24);
    chk("fair_sb_empty", sb.size(), 0);
    tick(); tick();
    chk("fire_hold", {31'd0, bus.fire}, 1);
    chk("fire_no_out", {31'd0, bus.add_valid}, 0);
    bus.fire_ack = 1'b1;
    tick();
    bus.fire_ack = 1'b0;
    chk("fire_clear", {31'd0, bus.fire}, 0);

    // Column-full stall: requester 0 sends a fourth col-1 partial
    set_req(0, 4, 2'd1, 8'd20);
    set_req(1, 3, 2'd2, 8'd1);
    set_req(2, 3, 2'd3, 8'd2);
    gq.delete();
    for (int k = 0; k < 40 && !bus.fire; k++) tick();
    chk("stall_fire", {31'd0, bus.fire}, 1);
    n0 = 0;
    foreach (gq[k]) if (gq[k] == 0) n0++;
    chk("stall_gnt0", n0, 3);
    chk("stall_rem0", rem[0], 1);
    for (int k = 0; k < 3; k++) begin
      peek();
      chk("stall_hold", {29'd0, bus.req_ready}, 0);
      tick();
    end
    bus.fire_ack = 1'b1;
    tick();
    bus.fire_ack = 1'b0;
    peek();
    chk("stall_regrant", {29'd0, bus.req_ready}, 32'b001);
    tick();
    chk("stall_gid", {30'd0, bus.grant_id}, 0);
    chk("stall_out_vld", {31'd0, bus.add_valid}, 1);
    tick();
    chk("stall_sb", sb.size(), 0);

    // Backpressure: adder stalls five cycles
    bus.add_ready = 1'b0;
    set_req(1, 3, 2'd2, 8'd7);
    set_req(2, 3, 2'd3, 8'd9);
    gq.delete();
    tick();
    for (int k = 0; k < 5; k++) begin
      peek();
      chk("bp_no_ready", {29'd0, bus.req_ready}, 0);
      chk("bp_hold", {22'd0, bus.add_valid, bus.add_col, bus.add_data}, {22'd0, 1'b1, 2'd2, 8'd7});
      tick();
    end
    bus.add_ready = 1'b1;
    steps = 0;
    while ((rem[1] > 0 || rem[2] > 0) && steps < 20) begin
      tick();
      steps++;
    end
    chk("bp_resume_cycles", steps, 5);
    chk("bp_ngrants", gq.size(), 6);
    for (int k = 0; k < 6 && k < gq.size(); k++) chk("bp_order", gq[k], (k % 2 == 0) ? 1 : 2);
    tick();
    chk("bp_sb", sb.size(), 0);

    // Tag-00 discard from requester 2
    set_req(2, 1, 2'd0, 8'hFF);
    peek();
    chk("t00_ready", {29'd0, bus.req_ready}, 32'b100);
    tick();
    chk("t00_err", {31'd0, bus.err_col}, 1);
    chk("t00_no_out", {31'd0, bus.add_valid}, 0);
    chk("t00_gid", {30'd0, bus.grant_id}, 2);
    tick();
    chk("t00_err_pulse", {31'd0, bus.err_col}, 0);
    // col 1 holds one partial; two more must complete the timestep
    set_req(0, 2, 2'd1, 8'd3);
    for (int k = 0; k < 20 && !bus.fire; k++) tick();
    chk("t00_fire", {31'd0, bus.fire}, 1);
    chk("t00_rem0", rem[0], 0);

    // Reset while in FIRE, with fire_ack asserted alongside
    rst = 1'b1;
    bus.fire_ack = 1'b1;
    tick();
    rst = 1'b0;
    bus.fire_ack = 1'b0;
    chk("mrst_fire", {31'd0, bus.fire}, 0);
    chk("mrst_add_valid", {31'd0, bus.add_valid}, 0);
    chk("mrst_gid", {30'd0, bus.grant_id}, 0);
    sb.delete();
    gq.delete();
    set_req(0, 1, 2'd1, 8'h11);
    set_req(1, 1, 2'd1, 8'h33);
    tick(); tick(); tick();
    chk("mrst_ngrants", gq.size(), 2);
    chk("mrst_g0", (gq.size() > 0) ? gq[0] : -1, 0);
    chk("mrst_g1", (gq.size() > 1) ? gq[1] : -1, 1);
    chk("mrst_gid1", {30'd0, bus.grant_id}, 1);
    chk("mrst_sb", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
